// File: rtl/revaluate_engine.sv
// Chi-style nonlinear revaluation over a 5x5 plane of LANE_W-bit lanes, streamed 1 lane or 1 row per cycle.
// Optional iota step on lane (0,0) is enabled by defining REVAL_IOTA_EN.
module revaluate_engine #(
  parameter int LANE_W          = 1,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [25*LANE_W-1:0]  in_data,
  input  logic                  in_valid,
`ifdef REVAL_IOTA_EN
  input  logic [LANE_W-1:0]     rc,
`endif
  output logic                  in_ready,
  output logic [25*LANE_W-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int STATE_W = 25 * LANE_W;
  localparam int GROUP_W = LANES_PER_CYCLE * LANE_W;

  if (LANES_PER_CYCLE != 1 && LANES_PER_CYCLE != 5) begin : g_bad_lanes_per_cycle
    $error("revaluate_engine: LANES_PER_CYCLE must be 1 or 5");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [STATE_W-1:0] in_reg;
  logic [STATE_W-1:0] out_reg;
  logic [2:0]         row;
  logic [2:0]         col;
  logic               idle_q;
  logic [GROUP_W-1:0] group;
  logic               last_group;
`ifdef REVAL_IOTA_EN
  logic [LANE_W-1:0]  rc_reg;
`endif

  // Lane L = 5*y+x sits at the MSB end for L=0, matching the bus layout.
  function automatic logic [LANE_W-1:0] lane_of(input logic [STATE_W-1:0] s, input int x, input int y);
    return s[(24 - (5*y + x))*LANE_W +: LANE_W];
  endfunction

  function automatic logic [LANE_W-1:0] chi_lane(input logic [STATE_W-1:0] s, input int x, input int y);
    return lane_of(s, x, y) ^ (~lane_of(s, (x + 1) % 5, y) & lane_of(s, (x + 2) % 5, y));
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    group = '0;
    for (int i = 0; i < LANES_PER_CYCLE; i++) begin
      group[(LANES_PER_CYCLE-1-i)*LANE_W +: LANE_W] =
        chi_lane(in_reg, (LANES_PER_CYCLE == 1) ? int'(col) : i, int'(row));
    end
`ifdef REVAL_IOTA_EN
    // Lane (0,0) is always the most significant lane of its group.
    if (row == 3'd0 && col == 3'd0) begin
      group[GROUP_W-1 -: LANE_W] = group[GROUP_W-1 -: LANE_W] ^ rc_reg;
    end
`endif
  end

  assign last_group = (row == 3'd4) && (LANES_PER_CYCLE == 5 || col == 3'd4);
  assign in_ready   = idle_q & ~rst;
  assign out_data   = out_reg;

  // NOTE: state is updated only with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide data registers are reset too, since an abort must present out_data=0.
      state     <= IDLE;
      in_reg    <= '0;
      out_reg   <= '0;
      row       <= '0;
      col       <= '0;
      idle_q    <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
`ifdef REVAL_IOTA_EN
      rc_reg    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg <= in_data;
`ifdef REVAL_IOTA_EN
            rc_reg <= rc;
`endif
            row    <= '0;
            col    <= '0;
            state  <= RUN;
            idle_q <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          out_reg <= {out_reg[STATE_W-GROUP_W-1:0], group};
          if (last_group) begin
            row       <= '0;
            col       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else if (LANES_PER_CYCLE == 5 || col == 3'd4) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            idle_q    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          idle_q    <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_revaluate_engine.sv
// Bench for revaluate_engine: three instances (1-bit/lane-serial, 8-bit/row-serial, 8-bit/lane-serial)
// checked against an index-based chi reference model; honours REVAL_IOTA_EN.
module tb_revaluate_engine;

`ifdef REVAL_IOTA_EN
  localparam bit IOTA = 1'b1;
`else
  localparam bit IOTA = 1'b0;
`endif

  localparam int LAT [3] = '{25, 5, 25};
  localparam int W   [3] = '{1, 8, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [24:0]  id_a;
  logic [199:0] id_b;
  logic [199:0] id_c;
`ifdef REVAL_IOTA_EN
  logic         rc_a;
  logic [7:0]   rc_b;
  logic [7:0]   rc_c;
`endif
  wire  [2:0]   ir;
  wire  [2:0]   ov;
  wire  [2:0]   bz;
  wire  [24:0]  od_a;
  wire  [199:0] od [3];

  int vectors     = 0;
  int miscompares = 0;

  assign od[0] = {175'd0, od_a};

  revaluate_engine #(.LANE_W(1), .LANES_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(id_a), .in_valid(iv[0]),
`ifdef REVAL_IOTA_EN
    .rc(rc_a),
`endif
    .in_ready(ir[0]), .out_data(od_a), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0]));

  revaluate_engine #(.LANE_W(8), .LANES_PER_CYCLE(5)) dut_b (
    .clk(clk), .rst(rst), .in_data(id_b), .in_valid(iv[1]),
`ifdef REVAL_IOTA_EN
    .rc(rc_b),
`endif
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1]));

  revaluate_engine #(.LANE_W(8), .LANES_PER_CYCLE(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(id_c), .in_valid(iv[2]),
`ifdef REVAL_IOTA_EN
    .rc(rc_c),
`endif
    .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2]));

  // Reference: unpack lanes into a 5x5 array, apply chi by index, repack.
  function automatic logic [199:0] chi_ref(input logic [199:0] s, input int w, input logic [7:0] rc);
    logic [7:0]   m;
    logic [7:0]   v;
    logic [7:0]   a [5][5];
    logic [199:0] r;
    m = 8'((9'd1 << w) - 9'd1);
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        a[x][y] = 8'(s >> ((24 - (5*y + x)) * w)) & m;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        v = (a[x][y] ^ (~a[(x+1)%5][y] & a[(x+2)%5][y])) & m;
        if (IOTA && x == 0 && y == 0) v = v ^ (rc & m);
        r = r | (200'(v) << ((24 - (5*y + x)) * w));
      end
    return r;
  endfunction

  function automatic logic [199:0] rand_state();
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[167:0], 32'($urandom())};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_v(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [199:0] data, input logic [7:0] rc);
    iv[d] = v;
    case (d)
      0:       id_a = data[24:0];
      1:       id_b = data;
      default: id_c = data;
    endcase
`ifdef REVAL_IOTA_EN
    case (d)
      0:       rc_a = rc[0];
      1:       rc_b = rc;
      default: rc_c = rc;
    endcase
`else
    if (rc != rc) $error("unreachable");
`endif
  endtask

  // Accept one state, wait (bounded) for the result, check latency, busy span and value; leaves DONE held.
  task automatic run_op(input int d, input logic [199:0] data, input logic [7:0] rc, input string tag,
                        output logic [199:0] res);
    int n;
    int bc;
    check_i({tag, " in_ready before accept"}, int'(ir[d]), 1);
    drive(d, 1'b1, data, rc);
    step();
    drive(d, 1'b0, rand_state(), ~rc);
    n  = 0;
    bc = 0;
    while (!ov[d] && n < 60) begin
      if (bz[d]) bc++;
      step();
      n++;
    end
    check_i({tag, " latency"}, n, LAT[d]);
    check_i({tag, " busy cycles"}, bc, LAT[d]);
    res = od[d];
    check_v({tag, " result"}, res, chi_ref(data, W[d], rc));
  endtask

  task automatic release_out(input int d, input string tag);
    ordy[d] = 1'b1;
    step();
    ordy[d] = 1'b0;
    check_i({tag, " out_valid after release"}, int'(ov[d]), 0);
    check_i({tag, " in_ready after release"}, int'(ir[d]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [199:0] res;
    logic [199:0] held;
    logic [199:0] s;
    logic [7:0]   rc;

    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, '0, '0);
    repeat (2) step();
    check_i("in_ready low during reset", int'(ir[1]), 0);
    rst = 1'b0;
    #1;

    for (int d = 0; d < 3; d++) begin
      check_i($sformatf("reset out_valid dut%0d", d), int'(ov[d]), 0);
      check_i($sformatf("reset busy dut%0d", d), int'(bz[d]), 0);
      check_i($sformatf("reset in_ready dut%0d", d), int'(ir[d]), 1);
      check_v($sformatf("reset out_data dut%0d", d), od[d], '0);
    end

    // Zero state, all ones, single lane (2,0).
    run_op(0, 200'h0, 8'h0, "zero", res);
    check_v("zero const", res, 200'h0);
    release_out(0, "zero");
    run_op(0, 200'h1FFFFFF, 8'h0, "ones", res);
    check_v("ones const", res, 200'h1FFFFFF);
    release_out(0, "ones");
    run_op(0, 200'h0400000, 8'h0, "lane20", res);
    check_v("lane20 const", res, 200'h1400000);
    release_out(0, "lane20");

    // Back-pressure: result held, inputs ignored while DONE.
    s = rand_state();
    run_op(0, s, 8'h0, "bp", held);
    for (int i = 0; i < 10; i++) begin
      drive(0, i[0], rand_state(), 8'($urandom()));
      step();
      check_v("bp out_data held", od[0], held);
      check_i("bp in_ready low", int'(ir[0]), 0);
      check_i("bp out_valid high", int'(ov[0]), 1);
    end
    drive(0, 1'b0, '0, '0);
    release_out(0, "bp");

    // Reset mid-RUN.
    drive(0, 1'b1, rand_state(), 8'h0);
    step();
    drive(0, 1'b0, '0, '0);
    repeat (10) step();
    check_i("mid-run busy", int'(bz[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_i("abort out_valid", int'(ov[0]), 0);
    check_i("abort busy", int'(bz[0]), 0);
    check_i("abort in_ready", int'(ir[0]), 1);
    check_v("abort out_data", od[0], '0);
    run_op(0, 200'h0400000, 8'h0, "post-abort", res);
    check_v("post-abort const", res, 200'h1400000);
    release_out(0, "post-abort");

    // Reset while DONE with no consumer.
    run_op(1, rand_state(), 8'h0, "done-abort", res);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_i("done-abort out_valid", int'(ov[1]), 0);
    check_v("done-abort out_data", od[1], '0);
    check_i("done-abort in_ready", int'(ir[1]), 1);

    // Random states on every configuration.
    for (int i = 0; i < 100; i++) begin
      rc = 8'($urandom());
      run_op(1, rand_state(), rc, "rand row", res);
      release_out(1, "rand row");
    end
    for (int i = 0; i < 15; i++) begin
      rc = 8'($urandom());
      run_op(0, rand_state(), rc, "rand lane1", res);
      release_out(0, "rand lane1");
      run_op(2, rand_state(), rc, "rand lane8", res);
      release_out(2, "rand lane8");
    end

    // Iota on lane (0,0) only.
    run_op(2, 200'h0, 8'h81, "iota", res);
    check_v("iota const", res, IOTA ? {8'h81, 192'd0} : 200'd0);
    release_out(2, "iota");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
